vram_burst_reader: RTL
======================

Name: vram_burst_reader

Overview:
- Single-clock burst fetch engine that drives the 16-bit GPU-side read port of the Z80/GPU shared dual-port RAMs (1024 x 16 view, 2-cycle registered read latency).
- On a start command it issues sequential word reads from a base address.
- It absorbs the memory read latency with a credit-limited FIFO and streams words to a downstream graphics consumer over a valid/ready handshake.
- It sits between the tile/sprite line engines and the shared-RAM port B.

Parameters:
- ADDR_W, 10, word address width of the RAM port (1024 words)
- DATA_W, 16, RAM port data width
- LEN_W, 11, burst length counter width (0..1024 words)
- RD_LAT, 2, cycles from mem_rden asserted to valid mem_q
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+1, power of two

Ports:
- clock  in  1  sole clock; RAM port B clock is tied to the same net
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle burst request; sampled only in IDLE
- base_addr  in  ADDR_W  first word address of burst
- word_cnt  in  LEN_W  number of words to fetch (0..1024)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at burst completion
- mem_rden  out  1  read enable to RAM port B
- mem_addr  out  ADDR_W  read address to RAM port B
- mem_q  in  DATA_W  read data from RAM port B, valid RD_LAT cycles after mem_rden
- out_valid  out  1  out_data holds a word
- out_ready  in  1  consumer accepts word when out_valid & out_ready
- out_data  out  DATA_W  fetched word
- out_last  out  1  qualifies the final word of the burst

Behaviour:
- Reset: all outputs 0 (busy, done, mem_rden, mem_addr, out_valid, out_data, out_last). FIFO flushed, in-flight pipe cleared, FSM to IDLE. Reset mid-burst abandons the burst with no done pulse.
- FSM states:
  - IDLE: start=1 with word_cnt>0 -> FETCH; load addr=base_addr, issue_left=word_cnt, recv_left=word_cnt; busy=1 next cycle. start=1 with word_cnt=0 -> DONE with no memory reads.
  - FETCH: issues reads. When issue_left reaches 0 -> DRAIN.
  - DRAIN: waits for the last word to be popped -> DONE.
  - DONE: done=1 and busy=0 for exactly one cycle -> IDLE.
- start is ignored outside IDLE.
- Issue rule in FETCH: mem_rden=1 iff issue_left>0 and (fifo_count + inflight) < FIFO_DEPTH.
  - inflight = population count of an RD_LAT-deep valid shift register fed by mem_rden.
  - Each issue increments addr and decrements issue_left.
- Address wrap: addr increments modulo 2^ADDR_W (1023 -> 0).
- mem_addr holds its last value while mem_rden=0.
- Capture: when the tail of the valid shift register is 1, push mem_q into the FIFO. The credit rule guarantees the FIFO is never full at push.
- FIFO is first-word-fall-through; out_valid = !empty.
- Simultaneous push and pop in one cycle is legal; count is unchanged.
- out_last=1 when the FIFO head is the final word, i.e. recv_left==1 counted at pop.
- recv_left decrements on each handshake.
- Throughput: with out_ready held high, one word per cycle after an initial RD_LAT+1 cycle latency (start to first out_valid).
- Back-pressure: out_ready=0 stalls issue once credits are exhausted. No word is dropped or duplicated, and out_data stays stable while out_valid & !out_ready.
- done asserts the cycle after the handshake of the out_last word.

Decomposition:
- Package vram_reader_pkg: FSM state enum (IDLE, FETCH, DRAIN, DONE), RD_LAT default, and a function computing the credit-check width.
- One sub-module: sync_fifo_fwft (DATA_W wide, FIFO_DEPTH deep, push/pop/count/empty/full), reusable by other line engines.

Test Plan:
- Bench uses a behavioural 2-cycle 1024x16 RAM model preloaded with mem[i]=i^16'hA5A5.
- Reset, then idle 5 cycles -> all outputs 0, mem_rden never asserted.
- start with base_addr=10'h010, word_cnt=8, out_ready=1:
  - out_data sequence mem[0x010..0x017], one per cycle.
  - out_last only on the 0x017 word.
  - done pulse one cycle after it; 8 total mem_rden cycles.
- base_addr=10'h3FE, word_cnt=4 -> reads 0x3FE, 0x3FF, 0x000, 0x001 in order.
- word_cnt=64 with out_ready toggling randomly (and a 20-cycle stall):
  - all 64 words delivered in order, no loss or duplicates.
  - fifo_count+inflight never exceeds 4; out_data stable during stall.
- word_cnt=0 -> done pulse 2 cycles after start, busy high 1 cycle, no mem_rden, no out_valid.
- Mid-burst:
  - reset after word 3 of a 16-word burst -> next cycle all outputs 0, no done pulse.
  - a following start at base 0x100, count 2 returns only mem[0x100], mem[0x101].
  - start pulsed while busy is ignored.

Source files
------------

// File: rtl/vram_reader_pkg.sv
// Shared types and sizing helpers for the VRAM burst reader.
// The credit width must hold fifo occupancy plus in-flight reads.
package vram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } rd_state_e;

    localparam int RD_LAT_DEF = 2;

    function automatic int crd_w(input int depth, input int lat);
        return $clog2(depth + lat + 1);
    endfunction

endpackage

// File: rtl/vram_burst_reader_if.sv
// RAM port B read bus plus the outgoing word stream.
// master = burst reader, slave = RAM and consumer side.
interface vram_burst_reader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);

    logic              mem_rden;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_q;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output mem_rden,
        output mem_addr,
        input  mem_q,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport slave (
        input  mem_rden,
        input  mem_addr,
        output mem_q,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO, power-of-two depth.
// The head word is presented while not empty; zero when empty.
module sync_fifo_fwft #(
    parameter  int W     = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          wr;
    logic          rd;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rd    = pop && !empty;
    // a full fifo still accepts a word when the head leaves this cycle
    assign wr    = push && (!full || rd);
    assign dout  = empty ? '0 : mem[rp];

    always_ff @(posedge clock) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr)
                wp <= wp + 1'b1;
            if (rd)
                rp <= rp + 1'b1;
            if (wr && !rd)
                count <= count + 1'b1;
            else if (rd && !wr)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr)
            mem[wp] <= din;
    end

endmodule

// File: rtl/vram_burst_reader.sv
// Burst fetch engine on shared-RAM port B with credit-limited
// read issue and a FWFT output FIFO feeding a valid/ready consumer.
module vram_burst_reader
    import vram_reader_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 11,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [LEN_W-1:0]   word_cnt,
    output logic               busy,
    output logic               done,
    vram_burst_reader_if.master bus
);

    localparam int CW  = crd_w(FIFO_DEPTH, RD_LAT);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    rd_state_e         state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  issue_left;
    logic [LEN_W-1:0]  recv_left;
    logic [RD_LAT-1:0] vld_sr;
    logic [RD_LAT-1:0] sr_nxt;
    logic [FCW-1:0]    fcount;
    logic              fempty;
    logic              ffull;
    logic              push;
    logic              pop;
    logic [CW-1:0]     cnt_nxt;
    logic [CW-1:0]     infl_nxt;
    logic              credit_ok;

    assign push          = vld_sr[RD_LAT-1];
    assign bus.out_valid = !fempty;
    assign pop           = !fempty && bus.out_ready;
    assign bus.out_last  = !fempty && (recv_left == LEN_W'(1));

    sync_fifo_fwft #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (bus.mem_q),
        .pop   (pop),
        .dout  (bus.out_data),
        .count (fcount),
        .empty (fempty),
        .full  (ffull)
    );

    // mem_rden is registered, so credit is judged on next-cycle occupancy
    always_comb begin
        sr_nxt   = (vld_sr << 1) | RD_LAT'(bus.mem_rden);
        infl_nxt = '0;
        for (int i = 0; i < RD_LAT; i++)
            infl_nxt = infl_nxt + CW'(sr_nxt[i]);
        cnt_nxt   = CW'(fcount) + CW'(push) - CW'(pop);
        credit_ok = (cnt_nxt + infl_nxt) < CW'(FIFO_DEPTH);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus.mem_rden <= 1'b0;
            bus.mem_addr <= '0;
            addr         <= '0;
            issue_left   <= '0;
            recv_left    <= '0;
            vld_sr       <= '0;
        end else begin
            vld_sr       <= sr_nxt;
            done         <= 1'b0;
            bus.mem_rden <= 1'b0;
            if (pop)
                recv_left <= recv_left - 1'b1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        recv_left <= word_cnt;
                        if (word_cnt != '0) begin
                            state        <= FETCH;
                            bus.mem_rden <= 1'b1;
                            bus.mem_addr <= base_addr;
                            addr         <= base_addr + 1'b1;
                            issue_left   <= word_cnt - 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                FETCH: begin
                    if (issue_left == '0) begin
                        state <= DRAIN;
                    end else if (credit_ok) begin
                        bus.mem_rden <= 1'b1;
                        bus.mem_addr <= addr;
                        addr         <= addr + 1'b1;
                        issue_left   <= issue_left - 1'b1;
                    end
                end
                DRAIN: begin
                    if (pop && recv_left == LEN_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    // an empty burst arrives here still busy
                    if (busy) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            assert (!(push && ffull && !pop));
    end

endmodule
